// File: rtl/axis_rx_fifo_writer.sv
// AXI-Stream receive side of a packet FIFO: two-entry skid buffer feeding the
// async FIFO, beat/length accounting and a four-phase packet-ready handshake.
module axis_rx_fifo_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int PKT_LEN    = 256
) (
   input  logic                    wr_clk,
   input  logic                    wr_rst,
   input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                    S_AXIS_TVALID,
   output logic                    S_AXIS_TREADY,
   input  logic                    S_AXIS_TLAST,
   output logic [DATA_WIDTH-1:0]   fifo_din,
   output logic                    fifo_wr_en,
   input  logic                    fifo_full,
   output logic                    pkt_req,
   input  logic                    pkt_ack,
   output logic [3:0]              pkt_pending,
   output logic                    pkt_len_err,
   output logic                    strb_err,
   output logic                    pend_ovf,
   input  logic                    err_clr
);
   localparam int CNT_W  = $clog2(PKT_LEN) + 1;
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(PKT_LEN);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} hs_state_t;

   function automatic logic [3:0] pend_step(input logic [3:0] cur, input logic inc,
                                            input logic dec);
      logic [3:0] nxt;
      nxt = cur;
      if (inc && !dec && cur != 4'hF)
         nxt = cur + 4'd1;
      else if (dec && !inc && cur != 4'h0)
         nxt = cur - 4'd1;
      return nxt;
   endfunction

   function automatic logic sticky(input logic cur, input logic set, input logic clr);
      return set || (cur && !clr);
   endfunction

   logic                  out_valid, out_valid_n, skid_valid, skid_valid_n;
   logic                  out_last, out_last_n, skid_last, skid_last_n;
   logic [DATA_WIDTH-1:0] out_data, out_data_n, skid_data, skid_data_n;
   logic                  accept, out_ready;

   logic [CNT_W-1:0]      beat_cnt, cnt_n, cnt_inc;
   logic                  len_set, strb_set, ovf_set, pkt_done, ack_evt;
   logic                  ack_meta, ack_s;
   hs_state_t             state, state_n;
   logic                  req_n;

   assign accept     = S_AXIS_TVALID && S_AXIS_TREADY;
   assign out_ready  = !out_valid || !fifo_full;
   assign fifo_wr_en = out_valid && !fifo_full;
   assign fifo_din   = out_data;

   // Skid buffer: the skid entry refills the output entry whenever it drains,
   // and a new beat lands in whichever entry is free after that move.
   always_comb begin
      out_valid_n  = out_valid;
      out_last_n   = out_last;
      out_data_n   = out_data;
      skid_valid_n = skid_valid;
      skid_last_n  = skid_last;
      skid_data_n  = skid_data;
      if (out_ready)
         out_valid_n = 1'b0;
      if (skid_valid && out_ready) begin
         out_valid_n  = 1'b1;
         out_last_n   = skid_last;
         out_data_n   = skid_data;
         skid_valid_n = 1'b0;
      end
      if (accept) begin
         if (!out_valid_n) begin
            out_valid_n = 1'b1;
            out_last_n  = S_AXIS_TLAST;
            out_data_n  = S_AXIS_TDATA;
         end else begin
            skid_valid_n = 1'b1;
            skid_last_n  = S_AXIS_TLAST;
            skid_data_n  = S_AXIS_TDATA;
         end
      end
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         out_data      <= '0;
         skid_valid    <= 1'b0;
         skid_last     <= 1'b0;
         skid_data     <= '0;
         S_AXIS_TREADY <= 1'b0;
      end else begin
         out_valid     <= out_valid_n;
         out_last      <= out_last_n;
         out_data      <= out_data_n;
         skid_valid    <= skid_valid_n;
         skid_last     <= skid_last_n;
         skid_data     <= skid_data_n;
         S_AXIS_TREADY <= !skid_valid_n;
      end
   end

   // Beat accounting on written beats; a full-length run without TLAST wraps.
   assign cnt_inc = beat_cnt + CNT_W'(1);

   always_comb begin
      cnt_n   = beat_cnt;
      len_set = 1'b0;
      if (fifo_wr_en) begin
         if (out_last) begin
            cnt_n   = '0;
            len_set = (cnt_inc != LEN_FULL);
         end else if (cnt_inc == LEN_FULL) begin
            cnt_n   = '0;
            len_set = 1'b1;
         end else begin
            cnt_n = cnt_inc;
         end
      end
   end

   assign strb_set = accept && (S_AXIS_TSTRB != {STRB_W{1'b1}});
   assign pkt_done = fifo_wr_en && out_last;
   assign ack_evt  = (state == REQ) && ack_s;
   assign ovf_set  = pkt_done && !ack_evt && (pkt_pending == 4'hF);

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         beat_cnt    <= '0;
         pkt_pending <= 4'd0;
         pkt_len_err <= 1'b0;
         strb_err    <= 1'b0;
         pend_ovf    <= 1'b0;
         ack_meta    <= 1'b0;
         ack_s       <= 1'b0;
      end else begin
         beat_cnt    <= cnt_n;
         pkt_pending <= pend_step(pkt_pending, pkt_done, ack_evt);
         pkt_len_err <= sticky(pkt_len_err, len_set, err_clr);
         strb_err    <= sticky(strb_err, strb_set, err_clr);
         pend_ovf    <= sticky(pend_ovf, ovf_set, err_clr);
         ack_meta    <= pkt_ack;
         ack_s       <= ack_meta;
      end
   end

   // Handshake FSM toward the read domain.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state   <= IDLE;
         pkt_req <= 1'b0;
      end else begin
         state   <= state_n;
         pkt_req <= req_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (pkt_pending != 4'd0) state_n = REQ;
         REQ:      if (ack_s) state_n = WAIT_LOW;
         WAIT_LOW: if (!ack_s) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   always_comb begin
      req_n = (state_n == REQ);
   end

endmodule
